// File: rtl/cla_pkg.sv
// Shared definitions for the digit-serial CLA adder: slice width, FSM states
// and the counter-sizing helper.
package cla_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count n slices, never less than one so WIDTH=4 still has a counter.
   function automatic int cntWidth(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/cla_serial_adder_cla4.sv
// Four-bit carry-lookahead slice: all carries derived in parallel from
// generate/propagate terms rather than rippled.
module CLA_4_bit (
   output logic [3:0] sum,
   output logic       cout,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Digit-serial wide adder: one 4-bit CLA slice per clock, LSB slice first,
// with the inter-slice carry held in a register.
module cla_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int SLICES = WIDTH / SLICE_W;
   localparam int CNT_W  = cntWidth(SLICES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

   generate
      if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : gBadWidth
         $error("cla_serial_adder: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [SLICE_W-1:0] sliceA;
   logic [SLICE_W-1:0] sliceB;
   logic [SLICE_W-1:0] sliceSum;
   logic               sliceCout;

   assign sliceA = a_q[int'(count_q) * SLICE_W +: SLICE_W];
   assign sliceB = b_q[int'(count_q) * SLICE_W +: SLICE_W];

   CLA_4_bit uSlice (
      .sum  (sliceSum),
      .cout (sliceCout),
      .a    (sliceA),
      .b    (sliceB),
      .cin  (carry_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
      end
   end

   // cout/ovf are only refreshed on the MSB slice, so they survive the next accept
   // until that operation actually produces new values.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               sum_d   = '0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[int'(count_q) * SLICE_W +: SLICE_W] = sliceSum;
            carry_d = sliceCout;
            if (count_q == LAST) begin
               cout_d  = sliceCout;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sliceSum[SLICE_W-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed scoreboard bench for cla_serial_adder (WIDTH=16): expected results
// are queued at accept time and compared when out_valid appears.
module tb_cla_serial_adder;

   localparam int WIDTH  = 16;
   localparam int SLICES = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } result_t;

   result_t sb[$];
   int      compared   = 0;
   int      mismatched = 0;
   int      edgeCnt    = 0;
   int      lastAccept = 0;
   int      prevAccept = 0;

   cla_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic result_t model(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                     input logic opCin);
      result_t    r;
      logic [WIDTH:0] t;
      t      = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, opCin};
      r.sum  = t[WIDTH-1:0];
      r.cout = t[WIDTH];
      r.ovf  = (opA[WIDTH-1] == opB[WIDTH-1]) && (t[WIDTH-1] != opA[WIDTH-1]);
      return r;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                input logic opCin);
      int waited;
      a        = opA;
      b        = opB;
      cin      = opCin;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 40) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      sb.push_back(model(opA, opB, opCin));
      @(posedge clk);
      @(negedge clk);
      lastAccept = edgeCnt;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic checkOutput(input string tag, input int expLat);
      int      edges;
      result_t exp;
      edges = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      check({tag, "_latency"}, 32'(edges), 32'(expLat));
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         exp = sb.pop_front();
         check({tag, "_sum"},  32'(sum),  32'(exp.sum));
         check({tag, "_cout"}, 32'(cout), 32'(exp.cout));
         check({tag, "_ovf"},  32'(ovf),  32'(exp.ovf));
      end
   endtask

   task automatic releaseOutput(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_released_ready"}, 32'(in_ready), 32'd1);
   endtask

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             c;
   } op_t;

   initial begin
      op_t ops[3];
      ops[0] = '{a: 16'h0102, b: 16'h0304, c: 1'b0};
      ops[1] = '{a: 16'h8000, b: 16'h8000, c: 1'b1};
      ops[2] = '{a: 16'h0FFF, b: 16'h0001, c: 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_sum",       32'(sum),       32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Plain add, full carry ripple, signed overflow, overflow with carry-in.
      applyStimulus(16'h00C0, 16'h0020, 1'b0);
      in_valid = 1'b0;
      checkOutput("small", SLICES);
      releaseOutput("small");

      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      in_valid = 1'b0;
      checkOutput("ripple", SLICES);
      releaseOutput("ripple");

      applyStimulus(16'h7FFF, 16'h0001, 1'b0);
      in_valid = 1'b0;
      checkOutput("ovf_pos", SLICES);
      releaseOutput("ovf_pos");

      applyStimulus(16'h5555, 16'h3333, 1'b1);
      in_valid = 1'b0;
      checkOutput("ovf_cin", SLICES);
      releaseOutput("ovf_cin");

      // Backpressure with a competing request held on the input side.
      applyStimulus(16'h1234, 16'h1111, 1'b0);
      a = 16'hAAAA;
      b = 16'h0101;
      checkOutput("bp", SLICES);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_sum",   32'(sum),       32'h2345);
         check("bp_hold_ready", 32'(in_ready),  32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      releaseOutput("bp");
      applyStimulus(16'hAAAA, 16'h0101, 1'b0);
      in_valid = 1'b0;
      checkOutput("bp_pending", SLICES);
      releaseOutput("bp_pending");

      // Asynchronous reset two slices into an operation.
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sum",       32'(sum),       32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_busy",      32'(busy),      32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h0003, 16'h0004, 1'b0);
      in_valid = 1'b0;
      checkOutput("after_rst", SLICES);
      releaseOutput("after_rst");

      // Back-to-back with both handshakes held high.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         prevAccept = lastAccept;
         applyStimulus(ops[i].a, ops[i].b, ops[i].c);
         if (i > 0) check("b2b_gap", 32'(lastAccept - prevAccept - 1), 32'(SLICES + 1));
         checkOutput("b2b", SLICES);
         if (i == 2) in_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("b2b_pulse", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
      @(negedge clk);
      check("final_idle", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
